i2c_slave: RTL and testbench
============================

// Module: i2c_slave
// PURPOSE
//  I2C target (responder) answering the I2C_MASTER initiator on the same bus.
//  Oversamples SCL/SDA in the system clock domain, detects START/STOP, matches a
//  fixed 7-bit address, then receives write bytes or returns read bytes with ACK.
//  SDA is open-drain: the block only ever pulls low or releases (1'bz).
// PARAMETERS
//  SLAVE_ADDR  7'h77  7-bit bus address this target acknowledges
// PORTS
//  clk       in     1  system clock; SCL must stay >= 8 clk periods high and low
//  reset_n   in     1  asynchronous active-low reset
//  scl       in     1  bus clock, driven by the master
//  sda       inout  1  bus data; driven 1'b0 when sda_oe else 1'bz
//  tx_data   in     8  byte returned on the next read byte; sampled when tx_req pulses
//  tx_req    out    1  1-clk pulse: tx_data captured into the shift register
//  rx_data   out    8  last byte received in a write transfer
//  rx_valid  out    1  1-clk pulse: rx_data updated
//  busy      out    1  high from accepted START to STOP/abort
// BEHAVIOUR
//  Reset: sda_oe=0 (sda=z), tx_req=0, rx_data=8'h00, rx_valid=0, busy=0, state IDLE,
//   sync flops preset to 1 (idle bus).
//  Input path: scl, sda each through 2-FF synchroniser plus one history flop;
//   rise/fall = edge between history and synced value (3-clk detect latency).
//  START: sda fall while synced scl=1 -> ADDR, bit count 0, busy=1; legal from any
//   state (repeated START restarts the address phase, releases sda).
//  STOP: sda rise while scl=1 -> IDLE, sda released, busy=0, from any state;
//   a partial byte is discarded (no rx_valid).
//  Bits sampled on scl rise, MSB first; sda outputs change only on scl fall.
//  States:
//   IDLE      wait START; all bus activity ignored
//   ADDR      shift 8 bits (7 addr + R/W). On 8th fall: addr==SLAVE_ADDR -> sda_oe=1,
//             ADDR_ACK; else -> IGNORE (sda never driven)
//   ADDR_ACK  hold sda low through 9th SCL pulse; on 9th fall: R/W=0 -> release, WRITE;
//             R/W=1 -> load tx_data, tx_req pulse, drive bit7, READ
//   WRITE     shift 8 bits; on 8th fall: rx_data<=shift, rx_valid pulse, sda_oe=1,
//             WRITE_ACK. Every byte is ACKed (no receive back-pressure)
//   WRITE_ACK on 9th fall release sda, back to WRITE, count 0
//   READ      sda_oe=~shift[7] each fall; after 8th fall release sda, READ_ACK
//   READ_ACK  sample master ACK on 9th rise. ACK(0): on 9th fall reload tx_data,
//             tx_req pulse, drive bit7, READ. NACK(1): IGNORE, sda released
//   IGNORE    sda released; wait STOP or START
//  Bit counter 4 bits, cleared on START and on each 9th fall; no wrap beyond 9.
//  START/STOP take priority over a coincident scl edge in the same clk.
//  sda_oe only changes in the clk after a detected scl fall (hold-time safe).
//  Async reset mid-transfer: immediately releases sda, returns IDLE; the master
//   sees NACK/garbage; block resyncs on next START.
//  rx_valid and tx_req never assert in the same clk.
// TESTING
//  1 Write 0x77,W + 0xDA, STOP -> ACK low on both 9th clocks, rx_data=0xDA,
//    rx_valid exactly 1 clk, busy falls after STOP.
//  2 Write addr 0x50 -> sda stays z throughout, no rx_valid, state IGNORE until STOP.
//  3 Read 0x77,R, tx_data=0xA5, master NACK -> one tx_req, sda bits 1,0,1,0,0,1,0,1,
//    sda released on 9th clock, IDLE after STOP.
//  4 Read 2 bytes (ACK then NACK), tx_data 0x3C then 0xC3 -> two tx_req pulses,
//    both bytes seen on bus in order.
//  5 Write 3 bytes 0x01,0x02,0x03 -> three ACKs, three rx_valid pulses, values in order;
//    then STOP after 4 bits of a 4th byte -> no rx_valid, rx_data stays 0x03.
//  6 reset_n low during WRITE_ACK -> sda z same cycle, busy=0; following write of
//    0x77,W + 0x5A completes normally with rx_data=0x5A.

Source files
------------

// File: rtl/i2c_slave_if.sv
// Host-side signal bundle of the I2C target: bus clock input plus the byte
// handshake towards the local logic. SDA stays a plain inout on the target.
interface i2c_slave_if;
   logic       scl;
   logic [7:0] tx_data;
   logic       tx_req;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       busy;

   modport slave (
      input  scl,
      input  tx_data,
      output tx_req,
      output rx_data,
      output rx_valid,
      output busy
   );

   modport master (
      output scl,
      output tx_data,
      input  tx_req,
      input  rx_data,
      input  rx_valid,
      input  busy
   );
endinterface

// File: rtl/i2c_slave.sv
// I2C target with a fixed 7-bit address: oversampled SCL/SDA, START/STOP
// detection, byte receive with ACK and byte transmit with master ACK/NACK.
module i2c_slave #(
   parameter logic [6:0] SLAVE_ADDR = 7'h77
) (
   input  logic        clk,
   input  logic        reset_n,
   inout  wire         sda,
   i2c_slave_if.slave  bus
);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_ADDR      = 3'd1,
      ST_ADDR_ACK  = 3'd2,
      ST_WRITE     = 3'd3,
      ST_WRITE_ACK = 3'd4,
      ST_READ      = 3'd5,
      ST_READ_ACK  = 3'd6,
      ST_IGNORE    = 3'd7
   } state_t;

   logic       scl_meta_r, scl_sync_r, scl_hist_r;
   logic       sda_meta_r, sda_sync_r, sda_hist_r;
   state_t     state_r;
   logic [3:0] bit_cnt_r;
   logic [7:0] shift_r;
   logic       rw_r;
   logic       ack_r;
   logic       sda_oe_r;
   logic       tx_req_r;
   logic [7:0] rx_data_r;
   logic       rx_valid_r;
   logic       busy_r;

   logic scl_rise_s, scl_fall_s, start_s, stop_s, counting_s;

   assign scl_rise_s = scl_sync_r & ~scl_hist_r;
   assign scl_fall_s = ~scl_sync_r & scl_hist_r;
   assign start_s    = ~sda_sync_r & sda_hist_r & scl_sync_r;
   assign stop_s     = sda_sync_r & ~sda_hist_r & scl_sync_r;
   assign counting_s = (state_r != ST_IDLE) && (state_r != ST_IGNORE);

   assign sda          = sda_oe_r ? 1'b0 : 1'bz;
   assign bus.tx_req   = tx_req_r;
   assign bus.rx_data  = rx_data_r;
   assign bus.rx_valid = rx_valid_r;
   assign bus.busy     = busy_r;

   // Two-stage synchronisers plus history flop; preset high to match an idle bus.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         {scl_meta_r, scl_sync_r, scl_hist_r} <= 3'b111;
         {sda_meta_r, sda_sync_r, sda_hist_r} <= 3'b111;
      end else begin
         {scl_meta_r, scl_sync_r, scl_hist_r} <= {bus.scl, scl_meta_r, scl_sync_r};
         {sda_meta_r, sda_sync_r, sda_hist_r} <= {sda, sda_meta_r, sda_sync_r};
      end
   end

   // Protocol FSM; all bus-facing outputs are registered here.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r    <= ST_IDLE;
         bit_cnt_r  <= 4'd0;
         shift_r    <= 8'h00;
         rw_r       <= 1'b0;
         ack_r      <= 1'b1;
         sda_oe_r   <= 1'b0;
         tx_req_r   <= 1'b0;
         rx_data_r  <= 8'h00;
         rx_valid_r <= 1'b0;
         busy_r     <= 1'b0;
      end else begin
         tx_req_r   <= 1'b0;
         rx_valid_r <= 1'b0;
         if (start_s) begin
            state_r   <= ST_ADDR;
            bit_cnt_r <= 4'd0;
            sda_oe_r  <= 1'b0;
            busy_r    <= 1'b1;
         end else if (stop_s) begin
            state_r   <= ST_IDLE;
            bit_cnt_r <= 4'd0;
            sda_oe_r  <= 1'b0;
            busy_r    <= 1'b0;
         end else begin
            // Rises are counted; the count saturates at the 9th (ACK) clock.
            if (scl_rise_s && counting_s && (bit_cnt_r < 4'd9)) begin
               bit_cnt_r <= bit_cnt_r + 4'd1;
            end else begin
               bit_cnt_r <= bit_cnt_r;
            end
            case (state_r)
               ST_ADDR: begin
                  if (scl_rise_s) begin
                     shift_r <= {shift_r[6:0], sda_sync_r};
                  end else if (scl_fall_s && (bit_cnt_r == 4'd8)) begin
                     rw_r <= shift_r[0];
                     if (shift_r[7:1] == SLAVE_ADDR) begin
                        sda_oe_r <= 1'b1;
                        state_r  <= ST_ADDR_ACK;
                     end else begin
                        state_r  <= ST_IGNORE;
                     end
                  end else begin
                     shift_r <= shift_r;
                  end
               end
               ST_ADDR_ACK: begin
                  if (scl_fall_s && (bit_cnt_r == 4'd9)) begin
                     bit_cnt_r <= 4'd0;
                     if (rw_r) begin
                        shift_r  <= bus.tx_data;
                        tx_req_r <= 1'b1;
                        sda_oe_r <= ~bus.tx_data[7];
                        state_r  <= ST_READ;
                     end else begin
                        sda_oe_r <= 1'b0;
                        state_r  <= ST_WRITE;
                     end
                  end else begin
                     state_r <= state_r;
                  end
               end
               ST_WRITE: begin
                  if (scl_rise_s) begin
                     shift_r <= {shift_r[6:0], sda_sync_r};
                  end else if (scl_fall_s && (bit_cnt_r == 4'd8)) begin
                     rx_data_r  <= shift_r;
                     rx_valid_r <= 1'b1;
                     sda_oe_r   <= 1'b1;
                     state_r    <= ST_WRITE_ACK;
                  end else begin
                     shift_r <= shift_r;
                  end
               end
               ST_WRITE_ACK: begin
                  if (scl_fall_s && (bit_cnt_r == 4'd9)) begin
                     bit_cnt_r <= 4'd0;
                     sda_oe_r  <= 1'b0;
                     state_r   <= ST_WRITE;
                  end else begin
                     state_r <= state_r;
                  end
               end
               ST_READ: begin
                  if (scl_fall_s) begin
                     if (bit_cnt_r == 4'd8) begin
                        sda_oe_r <= 1'b0;
                        state_r  <= ST_READ_ACK;
                     end else begin
                        shift_r  <= {shift_r[6:0], 1'b0};
                        sda_oe_r <= ~shift_r[6];
                     end
                  end else begin
                     state_r <= state_r;
                  end
               end
               ST_READ_ACK: begin
                  if (scl_rise_s) begin
                     ack_r <= sda_sync_r;
                  end else if (scl_fall_s && (bit_cnt_r == 4'd9)) begin
                     bit_cnt_r <= 4'd0;
                     if (!ack_r) begin
                        shift_r  <= bus.tx_data;
                        tx_req_r <= 1'b1;
                        sda_oe_r <= ~bus.tx_data[7];
                        state_r  <= ST_READ;
                     end else begin
                        sda_oe_r <= 1'b0;
                        state_r  <= ST_IGNORE;
                     end
                  end else begin
                     ack_r <= ack_r;
                  end
               end
               ST_IDLE, ST_IGNORE: begin
                  sda_oe_r <= 1'b0;
               end
               default: begin
                  state_r  <= ST_IDLE;
                  sda_oe_r <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: bit-banged bus master, transaction-level reference
// model feeding scoreboards, and a monitor that checks every DUT output pulse.
module tb_i2c_slave;
   localparam int HALF = 10;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset_n;
   logic m_low;
   wire  sda;
   pullup (sda);
   assign sda = m_low ? 1'b0 : 1'bz;

   i2c_slave_if bus ();
   i2c_slave #(.SLAVE_ADDR(7'h77)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .sda     (sda),
      .bus     (bus)
   );

   int checks = 0;
   int errors = 0;

   logic [7:0] exp_rx_q[$];
   int         exp_tx_q[$];
   logic [7:0] dat[4];
   logic [7:0] rd_vals[4];
   logic [7:0] last_rx = 8'h00;
   int         tx_cnt  = 0;
   int         rd_base = 0;
   logic       prev_rxv = 1'b0;

   assign bus.tx_data = rd_vals[(tx_cnt - rd_base) % 4];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Monitor: pops the scoreboards whenever the DUT pulses an output.
   always @(negedge clk) begin
      if (bus.rx_valid) begin
         chk("rx_pulse_width", {31'd0, prev_rxv}, 32'd0);
         if (exp_rx_q.size() == 0) begin
            chk("rx_unexpected", 32'd1, 32'd0);
         end else begin
            chk("rx_data", {24'd0, bus.rx_data}, {24'd0, exp_rx_q.pop_front()});
         end
      end
      if (bus.tx_req) begin
         chk("tx_req_expected", exp_tx_q.size(), (exp_tx_q.size() > 0) ? exp_tx_q.size() : 1);
         if (exp_tx_q.size() > 0) void'(exp_tx_q.pop_front());
         tx_cnt++;
      end
      if (bus.rx_valid && bus.tx_req) chk("rx_tx_overlap", 32'd1, 32'd0);
      prev_rxv = bus.rx_valid;
   end

   task automatic clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic start_cond();
      m_low = 1'b1;
      clks(HALF);
      chk("busy_start", {31'd0, bus.busy}, 32'd1);
      bus.scl = 1'b0;
   endtask

   task automatic stop_cond();
      clks(3);
      m_low = 1'b1;
      clks(HALF - 3);
      bus.scl = 1'b1;
      clks(HALF);
      m_low = 1'b0;
      clks(HALF);
      chk("busy_stop", {31'd0, bus.busy}, 32'd0);
   endtask

   task automatic send_bit(input logic b, output logic obs);
      clks(3);
      m_low = ~b;
      clks(HALF - 3);
      bus.scl = 1'b1;
      clks(HALF / 2);
      obs = sda;
      clks(HALF / 2);
      bus.scl = 1'b0;
   endtask

   task automatic recv_bit(output logic b);
      clks(3);
      m_low = 1'b0;
      clks(HALF - 3);
      bus.scl = 1'b1;
      clks(HALF / 2);
      b = sda;
      clks(HALF / 2);
      bus.scl = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] v);
      logic       o;
      logic [7:0] obs;
      for (int i = 7; i >= 0; i--) begin
         send_bit(v[i], o);
         obs[i] = o;
      end
      chk("wr_bus", {24'd0, obs}, {24'd0, v});
   endtask

   task automatic recv_byte(output logic [7:0] v);
      logic b;
      for (int i = 7; i >= 0; i--) begin
         recv_bit(b);
         v[i] = b;
      end
   endtask

   // Reference model: only address 0x77 is acknowledged; matched writes
   // deliver every complete byte, partial bytes vanish at STOP.
   task automatic do_write(input logic [6:0] addr, input int n, input int part);
      logic match;
      logic a, o;
      match = (addr == 7'h77);
      start_cond();
      send_byte({addr, 1'b0});
      recv_bit(a);
      chk("addr_ack", {31'd0, a}, {31'd0, ~match});
      for (int i = 0; i < n; i++) begin
         if (match) begin
            exp_rx_q.push_back(dat[i]);
            last_rx = dat[i];
         end
         send_byte(dat[i]);
         recv_bit(a);
         chk("data_ack", {31'd0, a}, {31'd0, ~match});
      end
      for (int j = 0; j < part; j++) send_bit(1'($urandom_range(0, 1)), o);
      stop_cond();
      chk("rx_hold", {24'd0, bus.rx_data}, {24'd0, last_rx});
   endtask

   // Matched reads return the supplied bytes in order; unmatched reads see 0xFF.
   task automatic do_read(input logic [6:0] addr, input int n);
      logic       match;
      logic       a, o;
      logic [7:0] b;
      match = (addr == 7'h77);
      for (int i = 0; i < 4; i++) rd_vals[i] = dat[i];
      rd_base = tx_cnt;
      if (match) for (int i = 0; i < n; i++) exp_tx_q.push_back(i);
      start_cond();
      send_byte({addr, 1'b1});
      recv_bit(a);
      chk("addr_ack", {31'd0, a}, {31'd0, ~match});
      for (int i = 0; i < n; i++) begin
         recv_byte(b);
         chk("rd_byte", {24'd0, b}, match ? {24'd0, dat[i]} : 32'hFF);
         send_bit((i == n - 1), o);
         if (i == n - 1) chk("nack_released", {31'd0, o}, 32'd1);
      end
      stop_cond();
   endtask

   initial begin
      #5ms;
      errors++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      logic       a;
      logic [6:0] ad;
      int         n;
      for (int i = 0; i < 4; i++) begin
         dat[i]     = 8'h00;
         rd_vals[i] = 8'h00;
      end
      reset_n = 1'b0;
      bus.scl = 1'b1;
      m_low   = 1'b0;
      clks(3);
      chk("rst_sda", {31'd0, sda}, 32'd1);
      chk("rst_busy", {31'd0, bus.busy}, 32'd0);
      chk("rst_rx_data", {24'd0, bus.rx_data}, 32'd0);
      chk("rst_rx_valid", {31'd0, bus.rx_valid}, 32'd0);
      chk("rst_tx_req", {31'd0, bus.tx_req}, 32'd0);
      reset_n = 1'b1;
      clks(5);

      dat[0] = 8'hDA;
      do_write(7'h77, 1, 0);
      dat[0] = 8'h3E;
      do_write(7'h50, 1, 0);
      dat[0] = 8'hA5;
      do_read(7'h77, 1);
      dat[0] = 8'h3C; dat[1] = 8'hC3;
      do_read(7'h77, 2);
      dat[0] = 8'h01; dat[1] = 8'h02; dat[2] = 8'h03;
      do_write(7'h77, 3, 4);

      // Reset while the target holds the data ACK low.
      start_cond();
      send_byte(8'hEE);
      recv_bit(a);
      chk("addr_ack", {31'd0, a}, 32'd0);
      exp_rx_q.push_back(8'h11);
      send_byte(8'h11);
      clks(3);
      m_low = 1'b0;
      clks(HALF - 3);
      bus.scl = 1'b1;
      clks(HALF / 2);
      chk("wack_drive", {31'd0, sda}, 32'd0);
      reset_n = 1'b0;
      #1;
      chk("rst_mid_sda", {31'd0, sda}, 32'd1);
      chk("rst_mid_busy", {31'd0, bus.busy}, 32'd0);
      chk("rst_mid_rx_data", {24'd0, bus.rx_data}, 32'd0);
      last_rx = 8'h00;
      clks(2);
      reset_n = 1'b1;
      clks(HALF);
      dat[0] = 8'h5A;
      do_write(7'h77, 1, 0);

      for (int k = 0; k < 8; k++) begin
         ad = ($urandom_range(0, 2) != 0) ? 7'h77 : 7'($urandom);
         n  = $urandom_range(1, 3);
         for (int i = 0; i < 4; i++) dat[i] = 8'($urandom);
         if ($urandom_range(0, 1) != 0) do_read(ad, n);
         else do_write(ad, n, 0);
      end

      clks(20);
      chk("rx_queue_empty", exp_rx_q.size(), 32'd0);
      chk("tx_queue_empty", exp_tx_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
